forwarding_scoreboard: RTL and testbench
========================================

# forwarding_scoreboard

Tracks destination-register tags of in-flight instructions through the EX, MEM and WB stages of the 5-stage RISC-V pipeline. It produces the registered 2-bit operand-select codes that drive the EX-stage 3-input operand muxes, and the load-use stall request for the ID stage. It also keeps a saturating count of stall cycles. It sits beside the ID/EX pipeline register and is the control-side counterpart of the datapath forwarding muxes.

## Interface
- REG_ADDR_W, 5, register-address width
- CNT_W, 16, stall-counter width
- clk  in  1  pipeline clock
- arst  in  1  reset, asynchronous, active-high
- pipe_enable  in  1  global advance; 0 freezes all stage state
- flush  in  1  squash the ID instruction (taken branch)
- id_valid  in  1  ID slot holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  REG_ADDR_W  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- ex_fwd_sel_a, ex_fwd_sel_b  out  2  operand-A/B select for the EX instruction
- stall_id  out  1  load-use hazard; hold IF/ID, bubble EX
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Select encoding:
  - 00: register file.
  - 01: MEM-stage result (EX/MEM ALU output).
  - 10: WB-stage result.
  - 11: never driven.
- Three tag slots, EX, MEM and WB, each holding {valid, rd, reg_write, mem_read}.
- A slot "writes r" if valid && reg_write && rd == r && r != 0.
- Next select for source s, computed against the current EX and MEM slots. The register file is write-before-read, so the WB slot is not compared.
  - EX slot writes s and is not a load -> 01.
  - Else MEM slot writes s -> 10.
  - Else -> 00.
  - The EX match (newer) has priority over the MEM match.
  - An unused source (rsN_used=0) -> 00.
- stall_id is combinational: id_valid && !flush && EX slot valid && EX mem_read && EX rd != 0 && (rs1_used && rs1 == EX rd || rs2_used && rs2 == EX rd).
- On a clock edge with pipe_enable=1:
  - WB <= MEM and MEM <= EX.
  - If stall_id || flush || !id_valid: EX <= bubble (valid=0) and both selects <= 00.
  - Otherwise EX <= ID tags and the selects <= the computed codes.
- pipe_enable=0: all slots, selects and the counter hold. stall_id still reflects its inputs.
- stall_count increments on each cycle with stall_id && pipe_enable, saturating at 2^CNT_W-1 (no wrap).
- After a load-use stall, the consumer re-evaluates with the load in the MEM slot and receives select 10.

## Timing
- Reset (async assert, sync-deasserted externally): all slots invalid, selects 00, stall_count 0, so stall_id is 0.
- Select latency: 1 cycle. Codes computed from ID inputs at edge N are valid in EX during cycle N+1.
- stall_id has 0-cycle latency from the ID inputs.
- Load-use penalty: exactly 1 bubble per hazard.
- flush and stall_id in the same cycle: flush wins. stall_id is forced to 0, a bubble is inserted and the counter does not increment.
- Reset mid-operation discards all in-flight tags immediately.

## Structure
- Package riscv_fwd_pkg holds:
  - enum fwd_sel_t: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - struct stage_tag_t: valid, rd, reg_write, mem_read.
  - function is_writer(tag, reg).
- One sub-module: fwd_tag_reg, an enable/bubble-capable stage_tag_t register with async reset, instantiated three times.

## Test plan
- ALU chain: add x5 then sub x6,x5,x1 back-to-back -> sub's ex_fwd_sel_a=01. With one independent instruction between them -> 10. With two between -> 00.
- Double hazard: add x5, add x5, use x5 -> select 01 (newer wins). Writes to x0 never forward -> 00.
- Load-use: lw x7 followed by add x8,x7,x7 -> stall_id=1 for exactly 1 cycle and stall_count=1. The add then gets sel_a=sel_b=10.
- flush asserted with a pending load-use hazard -> stall_id=0, EX bubble with selects 00, and stall_count unchanged.
- pipe_enable=0 for 3 cycles mid-chain -> selects and stall_count frozen. Resuming produces the same codes as without the freeze.
- Counter saturation with CNT_W=2: 5 load-use stalls -> stall_count=3. Assert arst mid-stream -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/riscv_fwd_pkg.sv
// riscv_fwd_pkg: shared types and helpers for the EX-stage forwarding scoreboard
package riscv_fwd_pkg;

    localparam int RD_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            reg_write;
        logic            mem_read;
    } stage_tag_t;

    // x0 is hardwired to zero, so a write to it never produces a value worth forwarding
    function automatic logic is_writer(stage_tag_t tag, logic [RD_W-1:0] r);
        return tag.valid && tag.reg_write && tag.rd == r && r != '0;
    endfunction

    // A load in EX has no result yet; the load-use stall covers that case, so only MEM may supply it
    function automatic fwd_sel_t next_sel(stage_tag_t ex, stage_tag_t mem, logic used, logic [RD_W-1:0] r);
        return !used                                 ? FWD_RF  :
               is_writer(ex, r) && !ex.mem_read      ? FWD_MEM :
               is_writer(mem, r)                     ? FWD_WB  : FWD_RF;
    endfunction

endpackage

// File: rtl/forwarding_scoreboard_tag_reg.sv
// fwd_tag_reg: one pipeline-stage tag register with hold and bubble insertion
//   clk, arst : clock, async active-high reset (clears to an invalid tag)
//   en        : advance; 0 holds the tag
//   bubble    : load an invalid tag instead of d when advancing
//   d, q      : incoming and stored stage tag
module fwd_tag_reg
    import riscv_fwd_pkg::*;
(
    input  logic       clk,
    input  logic       arst,
    input  logic       en,
    input  logic       bubble,
    input  stage_tag_t d,
    output stage_tag_t q
);

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            q <= '0;
        else if (en)
            q <= bubble ? '0 : d;
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: EX operand-forward selects and load-use stall from in-flight rd tags
//   clk, arst                      : pipeline clock, async active-high reset
//   pipe_enable, flush             : global advance, squash of the ID instruction
//   id_*                           : tags and sources of the instruction in ID
//   ex_fwd_sel_a, ex_fwd_sel_b     : registered operand selects for the EX instruction
//   stall_id                       : combinational load-use hazard request
//   stall_count                    : saturating count of stalled cycles
module forwarding_scoreboard
    import riscv_fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  pipe_enable,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic [1:0]            ex_fwd_sel_a,
    output logic [1:0]            ex_fwd_sel_b,
    output logic                  stall_id,
    output logic [CNT_W-1:0]      stall_count
);

    stage_tag_t id_tag, ex_tag, mem_tag, wb_tag;
    fwd_sel_t   sel_a, sel_b;
    logic       bubble;

    assign id_tag = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

    assign stall_id = id_valid && !flush && ex_tag.valid && ex_tag.mem_read && ex_tag.rd != '0 &&
                      ((id_rs1_used && id_rs1 == ex_tag.rd) || (id_rs2_used && id_rs2 == ex_tag.rd));

    assign bubble = stall_id || flush || !id_valid;

    fwd_tag_reg u_ex  (.clk(clk), .arst(arst), .en(pipe_enable), .bubble(bubble), .d(id_tag),  .q(ex_tag));
    fwd_tag_reg u_mem (.clk(clk), .arst(arst), .en(pipe_enable), .bubble(1'b0),   .d(ex_tag),  .q(mem_tag));
    // The register file is write-before-read, so WB is tracked but never compared
    fwd_tag_reg u_wb  (.clk(clk), .arst(arst), .en(pipe_enable), .bubble(1'b0),   .d(mem_tag), .q(wb_tag));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sel_a <= FWD_RF;
            sel_b <= FWD_RF;
        end else if (pipe_enable) begin
            sel_a <= bubble ? FWD_RF : next_sel(ex_tag, mem_tag, id_rs1_used, id_rs1);
            sel_b <= bubble ? FWD_RF : next_sel(ex_tag, mem_tag, id_rs2_used, id_rs2);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            stall_count <= '0;
        else if (stall_id && pipe_enable && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end

    assign ex_fwd_sel_a = sel_a;
    assign ex_fwd_sel_b = sel_b;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb_forwarding_scoreboard: table, directed and random checks against an in-order pipeline model
module tb_forwarding_scoreboard;

    logic       clk = 0, arst = 1, pipe_enable = 0, flush = 0, id_valid = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic       id_rs1_used = 0, id_rs2_used = 0, id_reg_write = 0, id_mem_read = 0;
    logic [1:0] sel_a, sel_b, sel_a2, sel_b2;
    logic       stall, stall2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int nchk = 0, nerr = 0;

    always #5 clk = ~clk;

    forwarding_scoreboard dut (
        .clk(clk), .arst(arst), .pipe_enable(pipe_enable), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_fwd_sel_a(sel_a), .ex_fwd_sel_b(sel_b), .stall_id(stall), .stall_count(cnt)
    );

    forwarding_scoreboard #(.CNT_W(2)) dut2 (
        .clk(clk), .arst(arst), .pipe_enable(pipe_enable), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_fwd_sel_a(sel_a2), .ex_fwd_sel_b(sel_b2), .stall_id(stall2), .stall_count(cnt2)
    );

    // Model: the last three issued instructions (0 = EX, 1 = MEM, 2 = WB), bubbles as invalid entries
    typedef struct {bit v; int rd; bit rw; bit mr;} slot_t;
    slot_t mp[3];
    int    msa, msb, mc16, mc2;

    typedef struct {
        bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit rw; bit mr; bit fl; bit en;
        bit es; int ea; int eb; int ec;
    } vec_t;
    vec_t tbl[28];

    function automatic vec_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit rw, bit mr,
                                bit fl, bit en, bit es, int ea, int eb, int ec);
        vec_t r;
        r = '{v, rs1, rs2, u1, u2, rd, rw, mr, fl, en, es, ea, eb, ec};
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit writes(int k, int r);
        return mp[k].v && mp[k].rw && mp[k].rd == r && r != 0;
    endfunction

    function automatic int want_sel(bit used, int r);
        if (!used) return 0;
        if (writes(0, r) && !mp[0].mr) return 1;
        if (writes(1, r)) return 2;
        return 0;
    endfunction

    function automatic bit want_stall();
        return id_valid && !flush && mp[0].v && mp[0].mr && mp[0].rd != 0 &&
               ((id_rs1_used && int'(id_rs1) == mp[0].rd) || (id_rs2_used && int'(id_rs2) == mp[0].rd));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) mp[k] = '{0, 0, 0, 0};
        msa = 0; msb = 0; mc16 = 0; mc2 = 0;
    endtask

    task automatic drive(vec_t t);
        id_valid = t.v; id_rs1 = 5'(t.rs1); id_rs2 = 5'(t.rs2); id_rs1_used = t.u1; id_rs2_used = t.u2;
        id_rd = 5'(t.rd); id_reg_write = t.rw; id_mem_read = t.mr; flush = t.fl; pipe_enable = t.en;
    endtask

    // One cycle: compare mid-cycle, then advance the model across the rising edge
    task automatic cyc();
        bit st, bub;
        int na, nb;
        @(negedge clk);
        st = want_stall();
        chk("stall_id", stall, st);
        chk("sel_a", sel_a, msa);
        chk("sel_b", sel_b, msb);
        chk("stall_count", cnt, mc16);
        chk("stall_count_w2", cnt2, mc2);
        bub = st || flush || !id_valid;
        na = bub ? 0 : want_sel(id_rs1_used, id_rs1);
        nb = bub ? 0 : want_sel(id_rs2_used, id_rs2);
        @(posedge clk);
        if (pipe_enable) begin
            mp[2] = mp[1];
            mp[1] = mp[0];
            mp[0] = bub ? '{0, 0, 0, 0} : '{1, int'(id_rd), id_reg_write, id_mem_read};
            msa = na; msb = nb;
            if (st) begin
                mc16 = (mc16 < 65535) ? mc16 + 1 : mc16;
                mc2  = (mc2 < 3) ? mc2 + 1 : mc2;
            end
        end
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_sel_a"}, sel_a, 0);
        chk({tag, "_sel_b"}, sel_b, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_cnt"}, cnt, 0);
        chk({tag, "_cnt_w2"}, cnt2, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        arst = 0;

        tbl[0]  = mk(1, 1, 2, 1,1, 5, 1,0, 0,1, 0,0,0,0);
        tbl[1]  = mk(1, 5, 1, 1,1, 6, 1,0, 0,1, 0,0,0,0);
        tbl[2]  = mk(1,10,11, 1,1, 9, 1,0, 0,1, 0,1,0,0);
        tbl[3]  = mk(1, 6, 1, 1,1, 7, 1,0, 0,1, 0,0,0,0);
        tbl[4]  = mk(1,14,15, 1,1,13, 1,0, 0,1, 0,2,0,0);
        tbl[5]  = mk(1,14,15, 1,1,16, 1,0, 0,1, 0,0,0,0);
        tbl[6]  = mk(1, 7, 0, 1,1,17, 1,0, 0,1, 0,0,0,0);
        tbl[7]  = mk(1, 1, 1, 1,1, 5, 1,0, 0,1, 0,0,0,0);
        tbl[8]  = mk(1, 5, 1, 1,1, 5, 1,0, 0,1, 0,0,0,0);
        tbl[9]  = mk(1, 5, 5, 1,1,18, 1,0, 0,1, 0,1,0,0);
        tbl[10] = mk(1, 1, 1, 1,1, 0, 1,0, 0,1, 0,1,1,0);
        tbl[11] = mk(1, 0, 0, 1,1,19, 1,0, 0,1, 0,0,0,0);
        tbl[12] = mk(1, 1, 0, 1,0, 7, 1,1, 0,1, 0,0,0,0);
        tbl[13] = mk(1, 7, 7, 1,1, 8, 1,0, 0,1, 1,0,0,0);
        tbl[14] = mk(1, 7, 7, 1,1, 8, 1,0, 0,1, 0,0,0,1);
        tbl[15] = mk(1, 1, 2, 1,1,20, 1,0, 0,1, 0,2,2,1);
        tbl[16] = mk(1, 1, 0, 1,0, 9, 1,1, 0,1, 0,0,0,1);
        tbl[17] = mk(1, 9, 0, 1,1,10, 1,0, 1,1, 0,0,0,1);
        tbl[18] = mk(1, 1, 1, 1,1,21, 1,0, 0,1, 0,0,0,1);
        tbl[19] = mk(1,21,21, 1,1,22, 1,0, 0,0, 0,0,0,1);
        tbl[20] = mk(1,21,21, 1,1,22, 1,0, 0,0, 0,0,0,1);
        tbl[21] = mk(1,21,21, 1,1,22, 1,0, 0,0, 0,0,0,1);
        tbl[22] = mk(1,21,21, 1,1,22, 1,0, 0,1, 0,0,0,1);
        tbl[23] = mk(1,22,22, 1,1,24, 1,0, 0,0, 0,1,1,1);
        tbl[24] = mk(1,22,22, 1,1,24, 1,0, 0,0, 0,1,1,1);
        tbl[25] = mk(1,22,22, 1,1,24, 1,0, 0,1, 0,1,1,1);
        tbl[26] = mk(1, 2, 3, 1,1,25, 1,0, 0,1, 0,1,1,1);
        tbl[27] = mk(1, 2, 3, 1,1,26, 1,0, 0,1, 0,0,0,1);

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].es);
            chk($sformatf("tbl%0d_sel_a", i), sel_a, tbl[i].ea);
            chk($sformatf("tbl%0d_sel_b", i), sel_b, tbl[i].eb);
            chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].ec);
            cyc();
        end

        // Five load-use hazards: the 2-bit counter must stop at 3
        for (int i = 0; i < 5; i++) begin
            drive(mk(1, 1, 0, 1,0, 3, 1,1, 0,1, 0,0,0,0));
            cyc();
            drive(mk(1, 3, 3, 1,1, 4, 1,0, 0,1, 0,0,0,0));
            cyc();
            cyc();
        end
        chk("sat_cnt16", cnt, 6);
        chk("sat_cnt_w2", cnt2, 3);

        for (int i = 0; i < 600; i++) begin
            id_valid     = $urandom_range(0, 99) < 85;
            flush        = $urandom_range(0, 99) < 10;
            pipe_enable  = $urandom_range(0, 99) < 80;
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_rs1_used  = $urandom_range(0, 3) != 0;
            id_rs2_used  = $urandom_range(0, 3) != 0;
            id_rd        = 5'($urandom_range(0, 3));
            id_reg_write = $urandom_range(0, 3) != 0;
            id_mem_read  = $urandom_range(0, 3) == 0;
            cyc();
            if (i == 300) begin
                #3 arst = 1;
                #1 chk_zero("arst_mid");
                model_reset();
                @(posedge clk);
                #1 arst = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
